axilite_master_bridge: RTL
==========================

# axilite_master_bridge

Parametrised AXI4-Lite single-outstanding master that converts a simple level-held register request interface (`mstr_*`) into AXI4-Lite read/write transactions. It is the generalised successor of the fixed 44-bit/32-bit converter used by the DRAM test register path, with:
- configurable address width, data width, PROT value, timeout and timeout read-data pattern;
- sticky error reporting;
- optional error logging.

## Interface
Parameters:
- `ADDR_W`, 44 — byte address width.
- `DATA_W`, 32 — data width; legal values 32 or 64; strobe width `DATA_W/8`.
- `TO_CYCLES`, 10000 — transaction timeout in ACLK cycles; 0 disables the timeout.
- `PROT`, 3'b000 — value driven on `AWPROT` and `ARPROT`.
- `RD_TO_DATA`, {`DATA_W/32`{32'hDEAD_C0DE}} — `mstr_rd_data` returned on a read timeout.

Ports:
- `ACLK` in 1 — clock; all logic is in this single domain.
- `ARESETN` in 1 — reset, asynchronous assert, active-low.
- `mstr_addr` in `ADDR_W` — byte address.
- `mstr_wr_data` in `DATA_W`; `mstr_wr_byte_en` in `DATA_W/8`.
- `mstr_wr_en`, `mstr_rd_en` in 1 — level requests, held until the matching rdy is seen.
- `mstr_wr_rdy`, `mstr_rd_rdy` out 1 — completion, held until the matching en drops.
- `mstr_rd_data` out `DATA_W`.
- `busy` out 1 — high in every state except IDLE.
- AXI master outputs and inputs:
  - `AWADDR`, `AWPROT`, `AWVALID`, `AWREADY`
  - `WDATA`, `WSTRB`, `WVALID`, `WREADY`
  - `BRESP`, `BVALID`, `BREADY`
  - `ARADDR`, `ARPROT`, `ARVALID`, `ARREADY`
  - `RDATA`, `RRESP`, `RVALID`, `RREADY`
- `resp_err` out 2 — latest non-OKAY response, sticky.
- `to_err` out 1 — sticky timeout flag.
- `clear_errors` in 1 — single-cycle pulse.
- `err_addr` out `ADDR_W`; `err_cnt` out 16 — error log; see Configuration.

## Operation
State machine: IDLE → WADDR → WRESP → DONE, or IDLE → RADDR → RDATA → DONE.

- **IDLE:**
  - All VALID/READY outputs and both rdy outputs are 0; `mstr_rd_data` is held.
  - `mstr_wr_en` has priority over `mstr_rd_en` when both are high.
  - Write accept: register `AWADDR`/`WDATA`/`WSTRB`, raise `AWVALID` and `WVALID`, go to WADDR.
  - Read accept: register `ARADDR`, raise `ARVALID`, go to RADDR.
- **WADDR:**
  - Each VALID drops on the edge where its READY is sampled high; the two handshakes are independent and in either order.
  - Once both handshakes are done, raise `BREADY` and go to WRESP.
- **WRESP:** on `BVALID`, drop `BREADY`, set `mstr_wr_rdy`, go to DONE.
- **RADDR:** on `ARREADY`, drop `ARVALID`, raise `RREADY`, go to RDATA.
- **RDATA:** on `RVALID`, drop `RREADY`, capture `RDATA` into `mstr_rd_data`, set `mstr_rd_rdy`, go to DONE.
- **DONE:** when the active en is sampled low, clear both rdy outputs and go to IDLE.
- **Timeout counter:**
  - Loaded with `TO_CYCLES` in IDLE; decrements in WADDR/WRESP/RADDR/RDATA.
  - On reaching 0, all VALID/READY outputs drop, the transaction completes to DONE, `to_err` sets, and a read returns `RD_TO_DATA`.
- **Error flags:**
  - A completed response ≠ OKAY loads `resp_err`; an OKAY response leaves it unchanged.
  - `clear_errors` zeroes `resp_err`, `to_err` and the log in any state; a same-cycle error update wins over the clear.

## Timing
- Reset values: every output is 0, state is IDLE, and the counter is loaded with `TO_CYCLES`. `ARESETN` low mid-transaction aborts the transaction immediately; the slave must be reset together with the bridge.
- Minimum write latency, with READYs and `BVALID` already high: en sampled at edge 1, AW/W handshake at edge 2, B accepted at edge 3, `mstr_wr_rdy` high after edge 3.
- Read latency: identical structure, 3 edges.
- `mstr_rd_data` is valid from the same edge `mstr_rd_rdy` rises.
- Re-accept: DONE→IDLE takes one edge after en drops; the earliest next accept is the following edge.
- Timeout fires on the `TO_CYCLES`-th edge spent in the non-IDLE, non-DONE states.

## Configuration
`AXILITE_BRIDGE_ERR_LOG_EN`:
- **Defined:** on every errored completion (non-OKAY response or timeout), `err_addr` captures that transaction's address and `err_cnt` increments, saturating at 16'hFFFF.
- **Undefined:** `err_addr` and `err_cnt` are driven to constant 0 and no logging registers are generated.

## Test plan
- **Write, all READYs high, BRESP=OKAY:** wr to 0x123_4567_89A0, data 0xA5A5A5A5, strb 0xF → `AWADDR`/`WDATA` match; `mstr_wr_rdy` high 3 edges after accept; `resp_err`=0.
- **Split write handshake:** `WREADY` 4 cycles before `AWREADY` → `WVALID` drops first, `BREADY` rises only after the AW handshake, no duplicate beat.
- **Read with slave error:** `RVALID` with RRESP=2'b10, RDATA=0x1234 → `mstr_rd_data`=0x1234, `resp_err`=2'b10 held across a following OKAY read; `clear_errors` → 0.
- **Read timeout:** `TO_CYCLES`=16, `ARREADY` never asserted → `ARVALID` drops at edge 16, `mstr_rd_data`=0xDEADC0DE, `to_err`=1, `err_cnt`=1 (macro defined).
- **Simultaneous wr_en and rd_en:** → write performed first; after the rdy/en release, the held read runs next.
- **Mid-read reset:** `ARESETN` low during RDATA → all outputs 0 asynchronously; a new request after release completes normally.

Source files
------------

// File: rtl/axilite_master_bridge.sv
// axilite_master_bridge: single-outstanding AXI4-Lite master fed by a level-held
// mstr_* register request port; sticky resp/timeout flags; optional error log.
// Ports: ACLK/ARESETN, mstr_* request/completion, AXI4-Lite AW/W/B/AR/R master,
// resp_err/to_err/clear_errors, err_addr/err_cnt.
// Optional error log: define AXILITE_BRIDGE_ERR_LOG_EN to enable it.
module axilite_master_bridge #(
  parameter int ADDR_W = 44,
  parameter int DATA_W = 32,
  parameter int TO_CYCLES = 10000,
  parameter logic [2:0] PROT = 3'b000,
  parameter logic [DATA_W-1:0] RD_TO_DATA =
    {(DATA_W/32){32'hDEAD_C0DE}}
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [ADDR_W-1:0]   mstr_addr,
  input  logic [DATA_W-1:0]   mstr_wr_data,
  input  logic [DATA_W/8-1:0] mstr_wr_byte_en,
  input  logic                mstr_wr_en,
  input  logic                mstr_rd_en,
  output logic                mstr_wr_rdy,
  output logic                mstr_rd_rdy,
  output logic [DATA_W-1:0]   mstr_rd_data,
  output logic                busy,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [2:0]          AWPROT,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [2:0]          ARPROT,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY,
  output logic [1:0]          resp_err,
  output logic                to_err,
  input  logic                clear_errors,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [15:0]         err_cnt
);

  localparam int SW = DATA_W / 8;
  localparam int CW =
    (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] TO_LOAD = CW'(TO_CYCLES);
  localparam bit TO_EN = (TO_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [CW-1:0]     cnt, cnt_d;
  logic              is_wr, is_wr_d;
  logic [ADDR_W-1:0] awaddr_d, araddr_d;
  logic [2:0]        awprot_d, arprot_d;
  logic              awvalid_d, wvalid_d;
  logic              bready_d;
  logic              arvalid_d, rready_d;
  logic [DATA_W-1:0] wdata_d;
  logic [SW-1:0]     wstrb_d;
  logic              wr_rdy_d, rd_rdy_d;
  logic [DATA_W-1:0] rd_data_d;
  logic [1:0]        resp_err_d;
  logic              to_err_d;

  logic              to_hit;
  logic              rsp_ld;
  logic [1:0]        rsp_val;
  logic              to_set;
  logic              aw_ok, w_ok;

  assign busy = (state != S_IDLE);

  // to_hit marks the edge on which the counter reaches 0
  assign to_hit = TO_EN && (cnt == CW'(1));

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    is_wr_d    = is_wr;
    awaddr_d   = AWADDR;
    awprot_d   = AWPROT;
    awvalid_d  = AWVALID;
    wdata_d    = WDATA;
    wstrb_d    = WSTRB;
    wvalid_d   = WVALID;
    bready_d   = BREADY;
    araddr_d   = ARADDR;
    arprot_d   = ARPROT;
    arvalid_d  = ARVALID;
    rready_d   = RREADY;
    wr_rdy_d   = mstr_wr_rdy;
    rd_rdy_d   = mstr_rd_rdy;
    rd_data_d  = mstr_rd_data;
    rsp_ld     = 1'b0;
    rsp_val    = 2'b00;
    to_set     = 1'b0;
    aw_ok      = 1'b0;
    w_ok       = 1'b0;

    if (state == S_IDLE) begin
      cnt_d = TO_LOAD;
    end else if (state != S_DONE && TO_EN) begin
      cnt_d = cnt - CW'(1);
    end

    unique case (state)
      S_IDLE: begin
        if (mstr_wr_en) begin
          awaddr_d  = mstr_addr;
          awprot_d  = PROT;
          wdata_d   = mstr_wr_data;
          wstrb_d   = mstr_wr_byte_en;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          is_wr_d   = 1'b1;
          state_d   = S_WADDR;
        end else if (mstr_rd_en) begin
          araddr_d  = mstr_addr;
          arprot_d  = PROT;
          arvalid_d = 1'b1;
          is_wr_d   = 1'b0;
          state_d   = S_RADDR;
        end
      end
      S_WADDR: begin
        if (to_hit) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          wr_rdy_d  = 1'b1;
          to_set    = 1'b1;
          state_d   = S_DONE;
        end else begin
          // AW and W complete independently, in any order
          aw_ok = !AWVALID || AWREADY;
          w_ok  = !WVALID || WREADY;
          if (AWVALID && AWREADY) awvalid_d = 1'b0;
          if (WVALID && WREADY)   wvalid_d  = 1'b0;
          if (aw_ok && w_ok) begin
            bready_d = 1'b1;
            state_d  = S_WRESP;
          end
        end
      end
      S_WRESP: begin
        // a response arriving on the final cycle still counts
        if (BVALID) begin
          bready_d = 1'b0;
          wr_rdy_d = 1'b1;
          rsp_ld   = (BRESP != 2'b00);
          rsp_val  = BRESP;
          state_d  = S_DONE;
        end else if (to_hit) begin
          bready_d = 1'b0;
          wr_rdy_d = 1'b1;
          to_set   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_RADDR: begin
        if (to_hit) begin
          arvalid_d = 1'b0;
          rd_rdy_d  = 1'b1;
          rd_data_d = RD_TO_DATA;
          to_set    = 1'b1;
          state_d   = S_DONE;
        end else if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (RVALID) begin
          rready_d  = 1'b0;
          rd_data_d = RDATA;
          rd_rdy_d  = 1'b1;
          rsp_ld    = (RRESP != 2'b00);
          rsp_val   = RRESP;
          state_d   = S_DONE;
        end else if (to_hit) begin
          rready_d  = 1'b0;
          rd_data_d = RD_TO_DATA;
          rd_rdy_d  = 1'b1;
          to_set    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (is_wr ? !mstr_wr_en : !mstr_rd_en) begin
          wr_rdy_d = 1'b0;
          rd_rdy_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a same-cycle error update overrides the clear
    resp_err_d = clear_errors ? 2'b00 : resp_err;
    if (rsp_ld) resp_err_d = rsp_val;
    to_err_d = clear_errors ? 1'b0 : to_err;
    if (to_set) to_err_d = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt          <= TO_LOAD;
      is_wr        <= 1'b0;
      AWADDR       <= '0;
      AWPROT       <= '0;
      AWVALID      <= 1'b0;
      WDATA        <= '0;
      WSTRB        <= '0;
      WVALID       <= 1'b0;
      BREADY       <= 1'b0;
      ARADDR       <= '0;
      ARPROT       <= '0;
      ARVALID      <= 1'b0;
      RREADY       <= 1'b0;
      mstr_wr_rdy  <= 1'b0;
      mstr_rd_rdy  <= 1'b0;
      mstr_rd_data <= '0;
      resp_err     <= 2'b00;
      to_err       <= 1'b0;
    end else begin
      cnt          <= cnt_d;
      is_wr        <= is_wr_d;
      AWADDR       <= awaddr_d;
      AWPROT       <= awprot_d;
      AWVALID      <= awvalid_d;
      WDATA        <= wdata_d;
      WSTRB        <= wstrb_d;
      WVALID       <= wvalid_d;
      BREADY       <= bready_d;
      ARADDR       <= araddr_d;
      ARPROT       <= arprot_d;
      ARVALID      <= arvalid_d;
      RREADY       <= rready_d;
      mstr_wr_rdy  <= wr_rdy_d;
      mstr_rd_rdy  <= rd_rdy_d;
      mstr_rd_data <= rd_data_d;
      resp_err     <= resp_err_d;
      to_err       <= to_err_d;
    end
  end

`ifdef AXILITE_BRIDGE_ERR_LOG_EN
  logic err_ev;

  assign err_ev = rsp_ld || to_set;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (err_ev) begin
      err_addr <= is_wr ? AWADDR : ARADDR;
      if (clear_errors) begin
        err_cnt <= 16'd1;
      end else if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end else if (clear_errors) begin
      err_addr <= '0;
      err_cnt  <= '0;
    end
  end
`else
  assign err_addr = '0;
  assign err_cnt  = '0;
`endif

endmodule
